// File: rtl/fetch_pkg.sv
// Shared fetch-stage types: address/instruction widths and the IR register payload.
package fetch_pkg;
  localparam int unsigned ADDR_W  = 12;
  localparam int unsigned INSTR_W = 19;

  typedef logic [ADDR_W-1:0]  addr_t;
  typedef logic [INSTR_W-1:0] instr_t;

  localparam instr_t NOP_INSTR = '0;

  // Instruction register contents handed to decode
  typedef struct packed {
    instr_t instr;
    addr_t  pc;
    logic   valid;
  } ir_reg_t;
endpackage

// File: rtl/fetch_stage_if.sv
// Fetch-stage bus: redirect requests from decode, instruction memory port, IR to decode.
interface fetch_stage_if;
  import fetch_pkg::*;

  logic   stall;
  logic   jump_en;
  logic   call_en;
  logic   ret_en;
  addr_t  target;
  addr_t  imem_address;
  instr_t imem_instruction;
  instr_t ir;
  addr_t  ir_pc;
  logic   ir_valid;
  logic   stack_overflow;
  logic   stack_underflow;

  modport master (
    input  stall, jump_en, call_en, ret_en, target, imem_instruction,
    output imem_address, ir, ir_pc, ir_valid, stack_overflow, stack_underflow
  );

  modport slave (
    output stall, jump_en, call_en, ret_en, target, imem_instruction,
    input  imem_address, ir, ir_pc, ir_valid, stack_overflow, stack_underflow
  );
endinterface

// File: rtl/fetch_stage_return_stack.sv
// Return-address stack for call/return; full/empty/top are decoded from the entry count.
module return_stack
  import fetch_pkg::*;
#(
  parameter int unsigned DEPTH = 8
) (
  input  logic  clk,
  input  logic  rst,
  input  logic  push,
  input  logic  pop,
  input  addr_t din,
  output addr_t top_c,
  output logic  full_c,
  output logic  empty_c
);
  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  addr_t            mem [DEPTH];
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] top_cnt;

  assign full_c  = (cnt == CNT_W'(DEPTH));
  assign empty_c = (cnt == '0);
  assign top_cnt = cnt - CNT_W'(1);
  assign top_c   = mem[top_cnt[PTR_W-1:0]];

  // Contents are cleared on reset so a mid-run reset leaves no stale return addresses
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
      for (int i = 0; i < int'(DEPTH); i++) mem[i] <= '0;
    end else if (push && !full_c) begin
      mem[cnt[PTR_W-1:0]] <= din;
      cnt                 <= cnt + CNT_W'(1);
    end else if (pop && !empty_c) begin
      cnt <= top_cnt;
    end
  end
endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC, IR register, jump/call/return redirect.
// Return-address stack and its sticky flags exist only when RET_STACK_EN is defined.
module fetch_stage
  import fetch_pkg::*;
#(
  parameter int unsigned STACK_DEPTH = 8
) (
  input  logic          clk,
  input  logic          rst,
  fetch_stage_if.master bus
);
  addr_t   pc;
  addr_t   pc_nxt;
  addr_t   redirect_pc;
  logic    redirect;
  ir_reg_t ir_q;
  ir_reg_t ir_nxt;

  if (STACK_DEPTH < 2 || (STACK_DEPTH & (STACK_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("STACK_DEPTH must be a power of two and at least 2");
  end

`ifdef RET_STACK_EN
  logic  push;
  logic  pop;
  logic  stack_full;
  logic  stack_empty;
  logic  overflow_q;
  logic  underflow_q;
  addr_t stack_top;

  return_stack #(.DEPTH(STACK_DEPTH)) u_return_stack (
    .clk     (clk),
    .rst     (rst),
    .push    (push),
    .pop     (pop),
    .din     (ir_q.pc + ADDR_W'(1)),
    .top_c   (stack_top),
    .full_c  (stack_full),
    .empty_c (stack_empty)
  );

  // Redirect decode: ret > call > jump, only acted on for a valid IR
  always_comb begin
    redirect    = ir_q.valid & (bus.ret_en | bus.call_en | bus.jump_en);
    redirect_pc = bus.target;
    push        = 1'b0;
    pop         = 1'b0;
    if (ir_q.valid && bus.ret_en) begin
      pop         = ~stack_empty;
      redirect_pc = stack_empty ? '0 : stack_top;
    end else if (ir_q.valid && bus.call_en) begin
      push = ~stack_full;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      if (ir_q.valid && bus.ret_en && stack_empty) underflow_q <= 1'b1;
      if (ir_q.valid && !bus.ret_en && bus.call_en && stack_full) overflow_q <= 1'b1;
    end
  end

  assign bus.stack_overflow  = overflow_q;
  assign bus.stack_underflow = underflow_q;
`else
  // Without a stack a call is a plain jump and a return is not a redirect
  assign redirect    = ir_q.valid & (bus.call_en | bus.jump_en);
  assign redirect_pc = bus.target;

  assign bus.stack_overflow  = 1'b0;
  assign bus.stack_underflow = 1'b0;
`endif

  // Next PC / IR: redirect squashes the wrong-path fetch, stall freezes everything
  always_comb begin
    pc_nxt       = pc + ADDR_W'(1);
    ir_nxt.instr = bus.imem_instruction;
    ir_nxt.pc    = pc;
    ir_nxt.valid = 1'b1;
    if (redirect) begin
      pc_nxt       = redirect_pc;
      ir_nxt       = ir_q;
      ir_nxt.valid = 1'b0;
    end else if (bus.stall) begin
      pc_nxt = pc;
      ir_nxt = ir_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc   <= '0;
      ir_q <= '{instr: NOP_INSTR, pc: '0, valid: 1'b0};
    end else begin
      pc   <= pc_nxt;
      ir_q <= ir_nxt;
    end
  end

  assign bus.imem_address = pc;
  assign bus.ir           = ir_q.instr;
  assign bus.ir_pc        = ir_q.pc;
  assign bus.ir_valid     = ir_q.valid;
endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: instruction memory holds mem[k] = k+1,
// expected IR state is queued per step and compared one edge later.
module tb_fetch_stage;
  import fetch_pkg::*;

  typedef struct {
    logic  valid;
    addr_t ir_pc;
    addr_t addr;
    logic  ovf;
    logic  unf;
  } exp_t;

  exp_t sb[$];
  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;
  logic e_ovf = 1'b0;
  logic e_unf = 1'b0;
  int   prev;
  int   ra;

  fetch_stage_if bus();

  fetch_stage #(.STACK_DEPTH(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  assign bus.imem_instruction = INSTR_W'(bus.imem_address) + INSTR_W'(1);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_zero(input string phase);
    chk({phase, " ir"},       32'(bus.ir), 32'h0);
    chk({phase, " ir_pc"},    32'(bus.ir_pc), 32'h0);
    chk({phase, " ir_valid"}, 32'(bus.ir_valid), 32'h0);
    chk({phase, " imem_addr"},32'(bus.imem_address), 32'h0);
    chk({phase, " overflow"}, 32'(bus.stack_overflow), 32'h0);
    chk({phase, " underflow"},32'(bus.stack_underflow), 32'h0);
  endtask

  // Drive one cycle of requests, queue the expected post-edge state, then check it
  task automatic cyc(input logic s, input logic j, input logic c, input logic r, input int tgt,
                     input logic ev, input int epc, input int eaddr);
    exp_t e;
    bus.stall   = s;
    bus.jump_en = j;
    bus.call_en = c;
    bus.ret_en  = r;
    bus.target  = ADDR_W'(tgt);
    e.valid = ev;
    e.ir_pc = ADDR_W'(epc);
    e.addr  = ADDR_W'(eaddr);
    e.ovf   = e_ovf;
    e.unf   = e_unf;
    sb.push_back(e);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    chk("ir_valid",  32'(bus.ir_valid), 32'(e.valid));
    chk("ir_pc",     32'(bus.ir_pc), 32'(e.ir_pc));
    chk("ir",        32'(bus.ir), 32'(INSTR_W'(e.ir_pc) + INSTR_W'(1)));
    chk("imem_addr", 32'(bus.imem_address), 32'(e.addr));
    chk("overflow",  32'(bus.stack_overflow), 32'(e.ovf));
    chk("underflow", 32'(bus.stack_underflow), 32'(e.unf));
  endtask

  task automatic nrm(input int epc);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b1, epc, epc + 1);
  endtask

  task automatic jmp(input int tgt, input int cur);
    cyc(1'b0, 1'b1, 1'b0, 1'b0, tgt, 1'b0, cur, tgt);
  endtask

  initial begin
    rst         = 1'b1;
    bus.stall   = 1'b0;
    bus.jump_en = 1'b0;
    bus.call_en = 1'b0;
    bus.ret_en  = 1'b0;
    bus.target  = '0;
    repeat (2) @(posedge clk);
    #1;
    chk_zero("reset");
    rst = 1'b0;

    // free run from address 0
    for (int k = 0; k <= 4; k++) nrm(k);

    // stall three cycles at pc=5
    repeat (3) cyc(1'b1, 1'b0, 1'b0, 1'b0, 0, 1'b1, 4, 5);
    for (int k = 5; k <= 16; k++) nrm(k);

    // jump from 0x010 to 0x100; a redirect during the bubble is ignored
    jmp(12'h100, 12'h010);
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 12'h300, 1'b1, 12'h100, 12'h101);

    // call at 0x020 to 0x200, return at 0x205
    jmp(12'h020, 12'h100);
    nrm(12'h020);
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 12'h200, 1'b0, 12'h020, 12'h200);
    for (int k = 12'h200; k <= 12'h205; k++) nrm(k);
`ifdef RET_STACK_EN
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 0, 1'b0, 12'h205, 12'h021);
    nrm(12'h021);
    prev = 12'h021;
`else
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 0, 1'b1, 12'h206, 12'h207);
    nrm(12'h207);
    prev = 12'h207;
`endif

    // nine nested calls into an eight-entry stack
    jmp(12'h300, prev);
    nrm(12'h300);
    prev = 12'h300;
    for (int i = 0; i <= 8; i++) begin
`ifdef RET_STACK_EN
      if (i == 8) e_ovf = 1'b1;
`endif
      cyc(1'b0, 1'b0, 1'b1, 1'b0, 12'h400 + 16 * i, 1'b0, prev, 12'h400 + 16 * i);
      nrm(12'h400 + 16 * i);
      prev = 12'h400 + 16 * i;
    end

    // nine returns: eight real, last one underflows to 0
    for (int j = 0; j <= 8; j++) begin
`ifdef RET_STACK_EN
      ra = (j < 7) ? (12'h461 - 16 * j) : ((j == 7) ? 12'h301 : 0);
      if (j == 8) e_unf = 1'b1;
      cyc(1'b0, 1'b0, 1'b0, 1'b1, 0, 1'b0, prev, ra);
      nrm(ra);
      prev = ra;
`else
      cyc(1'b0, 1'b0, 1'b0, 1'b1, 0, 1'b1, prev + 1, prev + 2);
      nrm(prev + 2);
      prev = prev + 2;
`endif
    end

    // PC wraps from 0xFFF to 0x000
    jmp(12'hFFF, prev);
    nrm(12'hFFF);
    nrm(0);

    // redirect overrides stall
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 12'h050, 1'b0, 0, 12'h050);
    nrm(12'h050);
    nrm(12'h051);

    // asynchronous reset mid-stream clears everything before the next edge
    #3;
    rst = 1'b1;
    #1;
    chk_zero("async_reset");
    rst   = 1'b0;
    e_ovf = 1'b0;
    e_unf = 1'b0;
    nrm(0);
    nrm(1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
